// File: rtl/stopwatch_bcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd_ctrl
//  Description : Start/stop/clear/lap stopwatch keeping MM:SS as BCD digits,
//                gating the 1 Hz prescaler and feeding the 7-segment decoders.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_bcd_ctrl #(
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       run_enable,
    output logic [3:0] disp_min_tens,
    output logic [3:0] disp_min_ones,
    output logic [3:0] disp_sec_tens,
    output logic [3:0] disp_sec_ones,
    output logic       lap_active,
    output logic       wrap_pulse
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2
    } state_t;

    localparam logic [3:0] C_MAX_MIN_TENS = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] C_MAX_MIN_ONES = 4'(MAX_MINUTES % 10);

    state_t      r_state_q,      w_state_d;
    logic [15:0] r_live_q,       w_live_d;
    logic [15:0] r_latch_q,      w_latch_d;
    logic        r_lap_q,        w_lap_d;
    logic        r_wrap_q,       w_wrap_d;
    logic        r_start_prev_q, w_start_prev_d;
    logic        r_clear_prev_q, w_clear_prev_d;
    logic        r_lap_prev_q,   w_lap_prev_d;

    logic        w_start_edge;
    logic        w_clear_edge;
    logic        w_lap_edge;
    logic [15:0] w_inc;
    logic        w_inc_wrap;

    assign w_start_edge = btn_start_stop & ~r_start_prev_q;
    assign w_clear_edge = btn_clear      & ~r_clear_prev_q;
    assign w_lap_edge   = btn_lap        & ~r_lap_prev_q;

    // Live time plus one second; digits packed as {min_tens, min_ones, sec_tens, sec_ones}
    always_comb begin
        w_inc      = r_live_q;
        w_inc_wrap = 1'b0;
        if (r_live_q == {C_MAX_MIN_TENS, C_MAX_MIN_ONES, 4'd5, 4'd9}) begin
            w_inc      = '0;
            w_inc_wrap = 1'b1;
        end else if (r_live_q[3:0] != 4'd9) begin
            w_inc[3:0] = r_live_q[3:0] + 4'd1;
        end else begin
            w_inc[3:0] = 4'd0;
            if (r_live_q[7:4] != 4'd5) begin
                w_inc[7:4] = r_live_q[7:4] + 4'd1;
            end else begin
                w_inc[7:4] = 4'd0;
                if (r_live_q[11:8] != 4'd9) begin
                    w_inc[11:8] = r_live_q[11:8] + 4'd1;
                end else begin
                    w_inc[11:8]  = 4'd0;
                    w_inc[15:12] = r_live_q[15:12] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_live_d       = r_live_q;
        w_latch_d      = r_latch_q;
        w_lap_d        = r_lap_q;
        w_wrap_d       = 1'b0;
        w_start_prev_d = btn_start_stop;
        w_clear_prev_d = btn_clear;
        w_lap_prev_d   = btn_lap;

        if (r_state_q == S_RUNNING && tick) begin
            w_live_d = w_inc;
            w_wrap_d = w_inc_wrap;
        end

        // The latch captures the pre-increment value when a tick coincides
        if (r_state_q != S_IDLE && w_lap_edge) begin
            w_lap_d = ~r_lap_q;
            if (!r_lap_q) begin
                w_latch_d = r_live_q;
            end
        end

        case (r_state_q)
            S_IDLE: begin
                if (w_start_edge) w_state_d = S_RUNNING;
            end
            S_RUNNING: begin
                if (w_start_edge) w_state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (w_clear_edge) begin
                    w_state_d = S_IDLE;
                    w_live_d  = '0;
                    w_latch_d = '0;
                    w_lap_d   = 1'b0;
                end else if (w_start_edge) begin
                    w_state_d = S_RUNNING;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_live_q       <= '0;
            r_latch_q      <= '0;
            r_lap_q        <= 1'b0;
            r_wrap_q       <= 1'b0;
            r_start_prev_q <= 1'b0;
            r_clear_prev_q <= 1'b0;
            r_lap_prev_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_live_q       <= w_live_d;
            r_latch_q      <= w_latch_d;
            r_lap_q        <= w_lap_d;
            r_wrap_q       <= w_wrap_d;
            r_start_prev_q <= w_start_prev_d;
            r_clear_prev_q <= w_clear_prev_d;
            r_lap_prev_q   <= w_lap_prev_d;
        end
    end

    assign run_enable = (r_state_q == S_RUNNING);
    assign lap_active = r_lap_q;
    assign wrap_pulse = r_wrap_q;
    assign {disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones} =
        r_lap_q ? r_latch_q : r_live_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_bcd_ctrl
//  Description : Self-checking bench for stopwatch_bcd_ctrl against a
//                seconds-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_bcd_ctrl;

    localparam int MAX_MIN = 59;
    localparam int PERIOD  = (MAX_MIN + 1) * 60;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic bs = 1'b0;
    logic bc = 1'b0;
    logic bl = 1'b0;
    logic       run_enable, lap_active, wrap_pulse;
    logic [3:0] d_mt, d_mo, d_st, d_so;
    logic [18:0] dut_vec;
    logic [15:0] disp;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: elapsed time as a plain seconds count
    int m_sec   = 0;
    int m_latch = 0;
    int m_state = 0;   // 0 idle, 1 running, 2 paused
    bit m_lap = 0, m_wrap = 0, m_ps = 0, m_pc = 0, m_pl = 0;

    stopwatch_bcd_ctrl #(.MAX_MINUTES(MAX_MIN)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_start_stop(bs), .btn_clear(bc), .btn_lap(bl),
        .run_enable(run_enable),
        .disp_min_tens(d_mt), .disp_min_ones(d_mo),
        .disp_sec_tens(d_st), .disp_sec_ones(d_so),
        .lap_active(lap_active), .wrap_pulse(wrap_pulse)
    );

    assign disp    = {d_mt, d_mo, d_st, d_so};
    assign dut_vec = {run_enable, lap_active, wrap_pulse, disp};

    always #10 clk = ~clk;

    function automatic logic [18:0] exp_vec();
        int v;
        int mm;
        int ss;
        v  = m_lap ? m_latch : m_sec;
        mm = v / 60;
        ss = v % 60;
        return {(m_state == 1), m_lap, m_wrap,
                4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit c,
                                       input bit l, input bit t);
        int nsec, nlatch, nstate;
        bit nlap, se, ce, le;
        if (r) begin
            m_sec = 0; m_latch = 0; m_state = 0;
            m_lap = 0; m_wrap = 0; m_ps = 0; m_pc = 0; m_pl = 0;
            return;
        end
        se = s & !m_ps; ce = c & !m_pc; le = l & !m_pl;
        nsec = m_sec; nlatch = m_latch; nstate = m_state; nlap = m_lap;
        m_wrap = 0;
        if (m_state == 1 && t) begin
            if (m_sec == PERIOD - 1) begin
                nsec = 0;
                m_wrap = 1;
            end else begin
                nsec = m_sec + 1;
            end
        end
        if (m_state != 0 && le) begin
            if (!m_lap) nlatch = m_sec;
            nlap = !m_lap;
        end
        case (m_state)
            0: if (se) nstate = 1;
            1: if (se) nstate = 2;
            default: begin
                if (ce) begin
                    nstate = 0; nsec = 0; nlatch = 0; nlap = 0;
                end else if (se) begin
                    nstate = 1;
                end
            end
        endcase
        m_sec = nsec; m_latch = nlatch; m_state = nstate; m_lap = nlap;
        m_ps = s; m_pc = c; m_pl = l;
    endfunction

    task automatic cycle(input bit r, input bit s, input bit c, input bit l, input bit t);
        reset = r; bs = s; bc = c; bl = l; tick = t;
        @(posedge clk);
        model_step(r, s, c, l, t);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        tests_run++;
        if (dut_vec !== 19'h0) begin
            tests_failed++;
            $display("FAIL reset_state: dut=%h expected=%h", dut_vec, 19'h0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 1);
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL idle_ticks: dut=%h expected=%h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_start_count();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        tests_run++;
        if (run_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_latency: run_enable=%b expected=1", run_enable);
        end
        for (int i = 0; i < 3; i++) begin
            repeat (9) cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 1);
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL count_tick: dut=%h expected=%h", dut_vec, exp_vec());
            end
        end
        tests_run++;
        if (disp !== 16'h0003) begin
            tests_failed++;
            $display("FAIL count_three: disp=%h expected=0003", disp);
        end
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 1);
        tests_run++;
        if (run_enable !== 1'b0 || disp !== 16'h0003) begin
            tests_failed++;
            $display("FAIL pause_hold: run_enable=%b disp=%h expected 0/0003", run_enable, disp);
        end
    endtask

    task automatic test_wrap();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < PERIOD - 2; i++) begin
            cycle(0, 0, 0, 0, 1);
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL wrap_ramp: step=%0d dut=%h expected=%h", i, dut_vec, exp_vec());
            end
        end
        tests_run++;
        if (disp !== 16'h5958) begin
            tests_failed++;
            $display("FAIL preload_5958: disp=%h expected=5958", disp);
        end
        cycle(0, 0, 0, 0, 1);
        tests_run++;
        if (disp !== 16'h5959 || wrap_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL at_5959: disp=%h wrap=%b expected 5959/0", disp, wrap_pulse);
        end
        cycle(0, 0, 0, 0, 1);
        tests_run++;
        if (disp !== 16'h0000 || wrap_pulse !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_edge: disp=%h wrap=%b expected 0000/1", disp, wrap_pulse);
        end
        cycle(0, 0, 0, 0, 0);
        tests_run++;
        if (wrap_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL wrap_one_cycle: dut=%h expected=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_lap();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0);
        tests_run++;
        if (lap_active !== 1'b1 || disp !== 16'h0005) begin
            tests_failed++;
            $display("FAIL lap_freeze: lap=%b disp=%h expected 1/0005", lap_active, disp);
        end
        repeat (4) cycle(0, 0, 0, 1, 1);
        tests_run++;
        if (disp !== 16'h0005 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL lap_held: dut=%h expected=%h", dut_vec, exp_vec());
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        tests_run++;
        if (lap_active !== 1'b0 || disp !== 16'h0009) begin
            tests_failed++;
            $display("FAIL lap_release: lap=%b disp=%h expected 0/0009", lap_active, disp);
        end
    endtask

    task automatic test_clear();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (7) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        tests_run++;
        if (run_enable !== 1'b1 || disp !== 16'h0008) begin
            tests_failed++;
            $display("FAIL clear_ignored_running: run=%b disp=%h expected 1/0008", run_enable, disp);
        end
        cycle(0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        tests_run++;
        if (dut_vec !== 19'h0 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL clear_wins: dut=%h expected=%h", dut_vec, 19'h0);
        end
    endtask

    task automatic test_tick_pause_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        tests_run++;
        if (run_enable !== 1'b0 || disp !== 16'h0011) begin
            tests_failed++;
            $display("FAIL tick_with_pause: run=%b disp=%h expected 0/0011", run_enable, disp);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (9) cycle(0, 0, 0, 0, 1);
        tests_run++;
        if (disp !== 16'h0020) begin
            tests_failed++;
            $display("FAIL resume_count: disp=%h expected=0020", disp);
        end
        cycle(1, 0, 0, 0, 1);
        tests_run++;
        if (dut_vec !== 19'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: dut=%h expected=%h", dut_vec, 19'h0);
        end
    endtask

    task automatic test_random();
        bit s = 0, c = 0, l = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) s = !s;
            if ($urandom_range(0, 7) == 0) c = !c;
            if ($urandom_range(0, 6) == 0) l = !l;
            cycle(($urandom_range(0, 799) == 0), s, c, l, ($urandom_range(0, 2) != 0));
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_cycle: i=%0d dut=%h expected=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_wrap();
        test_lap();
        test_clear();
        test_tick_pause_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_bcd_ctrl.md
Name: stopwatch_bcd_ctrl

Overview:
- Consumes the 1 Hz one-cycle tick produced by the 26-bit prescaler counter (its terminal-count output, 50 MHz / 50,000,000).
- Runs a start/stop/clear/lap state machine and keeps elapsed time as four BCD digits (MM:SS).
- Drives the prescaler's enable input, so the sub-second phase freezes while the stopwatch is paused.
- Outputs feed the downstream 7-segment decoders.

Parameters:
MAX_MINUTES, 59, last minute value before wrap to 00:00; legal range 1..99.

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high; clears all state
tick  input  1  one-cycle pulse from prescaler terminal count
btn_start_stop  input  1  synchronized level; rising edge = start/pause toggle
btn_clear  input  1  synchronized level; rising edge = clear request
btn_lap  input  1  synchronized level; rising edge = lap hold toggle
run_enable  output  1  enable to prescaler; high only in RUNNING
disp_min_tens  output  4  displayed minutes tens digit, BCD
disp_min_ones  output  4  displayed minutes ones digit, BCD
disp_sec_tens  output  4  displayed seconds tens digit, BCD (0..5)
disp_sec_ones  output  4  displayed seconds ones digit, BCD
lap_active  output  1  high while display is frozen on a lap value
wrap_pulse  output  1  one-cycle pulse when time rolls over to 00:00

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; live time 00:00; lap latch 00:00; lap_active=0; wrap_pulse=0; run_enable=0.
  - Edge-detect registers cleared to 0. A button already held high when reset releases therefore produces one edge.
  - Reset mid-operation discards everything in the same edge.
- Edge detect: one register per button; edge = btn & ~btn_prev. Edges are evaluated in the same cycle they are detected.
- States: IDLE, RUNNING, PAUSED. run_enable = (state==RUNNING), decoded from the state register only.
- IDLE:
  - start edge -> RUNNING.
  - clear and lap edges ignored.
- RUNNING:
  - start edge -> PAUSED.
  - clear edge ignored.
  - lap edge toggles lap_active.
- PAUSED:
  - start edge -> RUNNING.
  - clear edge -> IDLE; live time=00:00, lap latch=00:00, lap_active=0.
  - lap edge toggles lap_active.
  - Start and clear edges in the same cycle: clear wins -> IDLE.
- Counting:
  - Live time increments by one second when tick=1 AND the current registered state is RUNNING. The new value is visible on the next cycle.
  - A tick in the same cycle as a pausing start edge is counted.
  - Ticks in IDLE/PAUSED are ignored. The upstream counter is held anyway, so none are expected.
- Digit arithmetic:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into minutes.
  - min_ones 9->0 carries into min_tens.
  - At minutes==MAX_MINUTES and seconds==59, the next tick loads 00:00 and registers wrap_pulse=1 for exactly the cycle in which 00:00 first appears.
  - No digit ever holds a non-BCD value.
- Lap:
  - On a lap edge that sets lap_active, the latch captures the live value of that cycle (pre-increment if tick coincides).
  - A lap edge that clears lap_active releases the display to live time on the next cycle.
  - Counting continues underneath while frozen.
- Display: disp_* = lap_active ? latch : live, taken from registers with no combinational path from inputs.
- Latency: button edge to state/run_enable change = 1 cycle; tick to displayed digit change = 1 cycle.

Test Plan:
1. Reset with all buttons low -> run_enable=0, display 00:00, lap_active=0, wrap_pulse=0; hold 5 cycles with ticks -> unchanged.
2. Start edge, then 3 ticks spaced 10 cycles apart -> run_enable=1 one cycle after the edge; display 00:03; start edge again -> run_enable=0, 00:03 held through 4 further ticks.
3. Force live time to 59:58 via ticks (MAX_MINUTES=59), apply 2 ticks -> 59:59, then 00:00 with wrap_pulse high for exactly one cycle.
4. Running at 00:05, lap edge -> display frozen at 00:05 and lap_active=1; 4 ticks -> still 00:05; lap edge -> display 00:09 next cycle.
5. Running at 00:07: clear edge -> ignored, still counting. Pause, then start and clear edges in the same cycle -> IDLE, 00:00, run_enable=0, lap_active=0.
6. Start edge coincident with a tick while RUNNING at 00:10 -> PAUSED and display 00:11; reset asserted mid-RUNNING at 00:20 -> 00:00 and IDLE on the next cycle.
